// File: rtl/qrng_pkg.sv
// Shared types and limits for the nested-loop range generator.
package qrng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } qrng_state_e;

    localparam int NDIM_MAX = 8;

endpackage

// File: rtl/dti_s_if.sv
// Streaming data interface carrying one data word plus a queue-level eot flag.
// A word transfers on a rising clock edge where dvalid & dready are both 1; once dvalid is
// raised the producer holds data, and keeps dvalid high, until that transfer happens.
interface dti_s_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         dvalid;
    logic         dready;
    logic         eot;

    modport producer (output data, output dvalid, output eot, input dready);
    modport consumer (input data, input dvalid, input eot, output dready);
endinterface

// File: rtl/qrng_dim.sv
// One loop level: element index, running row value and the latched count/increment.
module qrng_dim #(
    parameter int W_DATA = 16,
    parameter int W_CNT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              carry_in,
    input  logic [W_CNT-1:0]  cnt,
    input  logic [W_DATA-1:0] incr,
    input  logic [W_DATA-1:0] base_in,
    output logic              last,
    output logic [W_DATA-1:0] row,
    output logic [W_DATA-1:0] row_inc
);

    logic [W_CNT-1:0]  idx_q;
    logic [W_CNT-1:0]  cnt_q;
    logic [W_DATA-1:0] incr_q;
    logic [W_DATA-1:0] row_q;

    // A level only moves when every lower level is at its last element; on wrap it restarts
    // from the row value the incrementing level above has just produced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            incr_q <= '0;
            row_q  <= '0;
        end else if (load) begin
            idx_q  <= '0;
            cnt_q  <= cnt;
            incr_q <= incr;
            row_q  <= base_in;
        end else if (step && carry_in) begin
            if (last) begin
                idx_q <= '0;
                row_q <= base_in;
            end else begin
                idx_q <= idx_q + W_CNT'(1);
                row_q <= row_inc;
            end
        end
    end

    assign last    = (idx_q == cnt_q - W_CNT'(1));
    assign row     = row_q;
    assign row_inc = row_q + incr_q;

endmodule

// File: rtl/qrnggen.sv
// NDIM-level nested-loop generator: one config word in, prod(cnt_d) words of
// base + sum(idx_d * incr_d) out, innermost level fastest, with per-level eot flags.
module qrnggen
    import qrng_pkg::*;
#(
    parameter int NDIM   = 2,
    parameter int W_DATA = 16,
    parameter int W_CNT  = 16,
    parameter int SIGNED = 0
) (
    input  logic        clk,
    input  logic        rst,
    dti_s_if.consumer   cfg,
    dti_s_if.producer   dout,
    output qrng_state_e dbg_state
);

    localparam int CFG_W = W_DATA + NDIM * (W_DATA + W_CNT);
    localparam int OUT_W = NDIM + W_DATA;

    typedef struct packed {
        logic [W_DATA-1:0] incr;
        logic [W_CNT-1:0]  cnt;
    } dim_t;

    typedef struct packed {
        dim_t [NDIM-1:0]   dim;
        logic [W_DATA-1:0] base;
    } cfg_t;

    cfg_t              cfg_w;
    qrng_state_e       state_q;
    qrng_state_e       state_d;
    logic [NDIM-1:0]   last;
    logic [NDIM-1:0]   carry_in;
    logic [NDIM-1:0]   eot;
    logic              eot_all;
    logic              cfg_ok;
    logic              load;
    logic              advance;
    logic [W_DATA-1:0] reload;
    logic [W_DATA-1:0] base_in;
    logic [W_DATA-1:0] row     [NDIM];
    logic [W_DATA-1:0] row_inc [NDIM];

    assign cfg_w = cfg_t'(cfg.data);

    for (genvar d = 0; d < NDIM; d++) begin : g_dim
        qrng_dim #(
            .W_DATA (W_DATA),
            .W_CNT  (W_CNT)
        ) u_dim (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .step     (advance),
            .carry_in (carry_in[d]),
            .cnt      (cfg_w.dim[d].cnt),
            .incr     (cfg_w.dim[d].incr),
            .base_in  (base_in),
            .last     (last[d]),
            .row      (row[d]),
            .row_inc  (row_inc[d])
        );
    end

    // carry_in[d]: all levels below d are on their last element; eot[d] includes level d itself.
    always_comb begin
        logic c;
        c        = 1'b1;
        carry_in = '0;
        eot      = '0;
        for (int d = 0; d < NDIM; d++) begin
            carry_in[d] = c;
            c           = c & last[d];
            eot[d]      = c;
        end
        eot_all = c;
    end

    // The single level that increments this step supplies the restart row for all levels below it.
    always_comb begin
        reload = '0;
        cfg_ok = 1'b1;
        for (int d = 0; d < NDIM; d++) begin
            if (carry_in[d] && !last[d]) begin
                reload = row_inc[d];
            end
            if (cfg_w.dim[d].cnt == '0) begin
                cfg_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg.dready  = 1'b0;
        dout.dvalid = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        case (state_q)
            IDLE: begin
                cfg.dready = 1'b1;
                load       = cfg.dvalid && cfg_ok;
                if (load) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                dout.dvalid = 1'b1;
                cfg.dready  = eot_all && dout.dready;
                advance     = dout.dready && !eot_all;
                if (dout.dready && eot_all) begin
                    load    = cfg.dvalid && cfg_ok;
                    state_d = load ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign base_in   = load ? cfg_w.base : reload;
    assign dout.data = {eot, row[0]};
    assign dout.eot  = 1'b0;
    assign dbg_state = state_q;

    a_shape: assert property (@(posedge clk)
        $bits(cfg.data) == CFG_W && $bits(dout.data) == OUT_W &&
        NDIM >= 1 && NDIM <= NDIM_MAX && (SIGNED == 0 || SIGNED == 1));

    a_hold: assert property (@(posedge clk) disable iff (!rst)
        (dout.dvalid && !dout.dready) |=> $stable(dout.data));

endmodule

// File: tb/tb_qrnggen.sv
// Directed bench for qrnggen: an unsigned 16-bit two-level instance and a signed 8-bit one.
module tb_qrnggen;
    import qrng_pkg::*;

    localparam int AW = 16;
    localparam int ACW = 16;
    localparam int A_CFG = AW + 2 * (AW + ACW);
    localparam int A_OUT = 2 + AW;
    localparam int BW = 8;
    localparam int BCW = 8;
    localparam int B_CFG = BW + 2 * (BW + BCW);
    localparam int B_OUT = 2 + BW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dti_s_if #(.W(A_CFG)) cfg_a ();
    dti_s_if #(.W(A_OUT)) dout_a ();
    dti_s_if #(.W(B_CFG)) cfg_b ();
    dti_s_if #(.W(B_OUT)) dout_b ();
    qrng_state_e st_a;
    qrng_state_e st_b;

    qrnggen #(.NDIM(2), .W_DATA(AW), .W_CNT(ACW), .SIGNED(0)) dut_a (
        .clk(clk), .rst(rst), .cfg(cfg_a), .dout(dout_a), .dbg_state(st_a)
    );
    qrnggen #(.NDIM(2), .W_DATA(BW), .W_CNT(BCW), .SIGNED(1)) dut_b (
        .clk(clk), .rst(rst), .cfg(cfg_b), .dout(dout_b), .dbg_state(st_b)
    );

    // ---------------- scoreboard ----------------
    logic [A_OUT-1:0] exp_q   [$];
    logic [B_OUT-1:0] exp_b_q [$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_a = 0;
    int hs_b = 0;
    int hs_cyc_last = 0;
    int hs_cyc_prev = 0;
    logic stall_a = 1'b0;
    logic [A_OUT-1:0] held_a = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst && dout_a.dvalid) begin
            if (stall_a) check("a_stall_hold", 64'(dout_a.data), 64'(held_a));
            stall_a = !dout_a.dready;
            held_a  = dout_a.data;
        end else begin
            stall_a = 1'b0;
        end
        if (rst && dout_a.dvalid && dout_a.dready) begin
            check("a_word_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) check("a_word", 64'(dout_a.data), 64'(exp_q.pop_front()));
            hs_a++;
            hs_cyc_prev = hs_cyc_last;
            hs_cyc_last = cyc;
        end
        if (rst && dout_b.dvalid && dout_b.dready) begin
            check("b_word_expected", 64'(exp_b_q.size() > 0), 64'(1));
            if (exp_b_q.size() > 0) check("b_word", 64'(dout_b.data), 64'(exp_b_q.pop_front()));
            hs_b++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [A_CFG-1:0] cfg_word_a(input logic [15:0] base, input logic [15:0] i0,
                                                    input logic [15:0] c0, input logic [15:0] i1,
                                                    input logic [15:0] c1);
        return {i1, c1, i0, c0, base};
    endfunction

    task automatic push_a(input logic [1:0] eot, input logic [15:0] val);
        exp_q.push_back({eot, val});
    endtask

    task automatic push_first_cfg();
        push_a(2'b00, 16'd100); push_a(2'b00, 16'd101); push_a(2'b01, 16'd102);
        push_a(2'b00, 16'd110); push_a(2'b00, 16'd111); push_a(2'b11, 16'd112);
    endtask

    task automatic send_a(input logic [A_CFG-1:0] d, output int waited);
        logic acc;
        cfg_a.data   = d;
        cfg_a.dvalid = 1'b1;
        waited = 0;
        acc = 1'b0;
        while (!acc && waited < 40) begin
            @(negedge clk);
            acc = cfg_a.dready;
            tick();
            waited++;
        end
        if (!acc) check("a_cfg_accept", 64'(acc), 64'(1));
        cfg_a.dvalid = 1'b0;
    endtask

    task automatic drain_a(input bit toggle);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            if (toggle) dout_a.dready = ~dout_a.dready;
            tick();
            n++;
        end
        check("a_drain", 64'(exp_q.size()), 64'(0));
        dout_a.dready = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    logic [A_CFG-1:0] cfg1;
    int w;
    int n;
    int hs_base;

    initial begin
        cfg1 = cfg_word_a(16'd100, 16'd1, 16'd3, 16'd10, 16'd2);
        cfg_a.data = '0; cfg_a.dvalid = 1'b0; cfg_a.eot = 1'b0; dout_a.dready = 1'b1;
        cfg_b.data = '0; cfg_b.dvalid = 1'b0; cfg_b.eot = 1'b0; dout_b.dready = 1'b1;
        #1 rst = 1'b0;
        #3;
        check("rst_a_dvalid", 64'(dout_a.dvalid), 64'(0));
        check("rst_a_cfg_ready", 64'(cfg_a.dready), 64'(1));
        check("rst_a_state", 64'(st_a), 64'(IDLE));
        check("rst_b_dvalid", 64'(dout_b.dvalid), 64'(0));
        #8 rst = 1'b1;
        tick();

        // basic 3x2 walk, sink always ready
        push_first_cfg();
        send_a(cfg1, w);
        check("s1_cfg_wait", 64'(w), 64'(1));
        check("s1_first_valid", 64'(dout_a.dvalid), 64'(1));
        check("s1_first_word", 64'(dout_a.data), 64'({2'b00, 16'd100}));
        drain_a(1'b0);
        check("s1_idle_dvalid", 64'(dout_a.dvalid), 64'(0));
        check("s1_idle_state", 64'(st_a), 64'(IDLE));

        // same walk with the sink stalling every other cycle
        push_first_cfg();
        send_a(cfg1, w);
        drain_a(1'b1);

        // back-to-back configs: the 1x1 word must follow 112 on the very next cycle
        push_first_cfg();
        push_a(2'b11, 16'd0);
        send_a(cfg1, w);
        send_a(cfg_word_a(16'd0, 16'd0, 16'd1, 16'd0, 16'd1), w);
        check("s3_cfg2_wait", 64'(w), 64'(6));
        drain_a(1'b0);
        check("s3_no_bubble", 64'(hs_cyc_last - hs_cyc_prev), 64'(1));

        // zero count on the outer level: consumed, no output
        send_a(cfg_word_a(16'd7, 16'd1, 16'd3, 16'd10, 16'd0), w);
        check("s4_zero_wait", 64'(w), 64'(1));
        check("s4_zero_state", 64'(st_a), 64'(IDLE));
        tick(); tick();
        check("s4_zero_dvalid", 64'(dout_a.dvalid), 64'(0));
        push_first_cfg();
        send_a(cfg1, w);
        drain_a(1'b0);

        // signed 8-bit instance: decrementing inner level wraps through zero
        exp_b_q.push_back({2'b00, 8'd2});
        exp_b_q.push_back({2'b00, 8'd1});
        exp_b_q.push_back({2'b00, 8'd0});
        exp_b_q.push_back({2'b11, 8'hFF});
        cfg_b.data = {8'h00, 8'd1, 8'hFF, 8'd4, 8'd2};
        cfg_b.dvalid = 1'b1;
        tick();
        cfg_b.dvalid = 1'b0;
        n = 0;
        while (exp_b_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check("s5_b_drain", 64'(exp_b_q.size()), 64'(0));
        check("s5_b_count", 64'(hs_b), 64'(4));
        check("s5_b_state", 64'(st_b), 64'(IDLE));

        // async reset after the second word abandons the transaction
        push_first_cfg();
        hs_base = hs_a;
        send_a(cfg1, w);
        n = 0;
        while (hs_a - hs_base < 2 && n < 20) begin
            tick();
            n++;
        end
        check("s6_two_words", 64'(hs_a - hs_base), 64'(2));
        rst = 1'b0;
        #1;
        check("s6_rst_dvalid", 64'(dout_a.dvalid), 64'(0));
        check("s6_rst_state", 64'(st_a), 64'(IDLE));
        exp_q.delete();
        tick();
        #2 rst = 1'b1;
        #1;
        check("s6_rel_cfg_ready", 64'(cfg_a.dready), 64'(1));
        check("s6_rel_dvalid", 64'(dout_a.dvalid), 64'(0));
        tick();
        tick();
        check("s6_rel_quiet", 64'(dout_a.dvalid), 64'(0));
        push_a(2'b00, 16'd500);
        push_a(2'b11, 16'd502);
        send_a(cfg_word_a(16'd500, 16'd2, 16'd2, 16'd100, 16'd1), w);
        drain_a(1'b0);
        tick();
        check("s6_end_state", 64'(st_a), 64'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
